// File: rtl/tnn_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tnn_run_ctrl
// Description : Run sequencer for one sequential TNN classifier. It accepts a
//               feature vector on a valid/ready stream and latches it onto the
//               classifier data bus. It then holds the classifier in reset for
//               one cycle and releases it for the fixed evaluation window of
//               FEAT_CNT+HIDDEN_CNT cycles. At the end of the window it
//               captures the prediction and offers it on a valid/ready result
//               stream until the consumer takes it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   in_valid       in   feature vector offered
//   in_ready       out  vector accepted this cycle (IDLE only)
//   in_data        in   FEAT_BITS*FEAT_CNT feature vector
//   tnn_data       out  registered vector to classifier data
//   tnn_rst        out  registered drive to classifier rst
//   tnn_prediction in   classifier prediction
//   out_valid      out  result available (DONE)
//   out_ready      in   consumer takes result
//   out_class      out  captured class
//   busy           out  high in every state except IDLE
//   run_cnt        out  completed output handshakes, saturating
//                       (present only when TNN_RUN_CNT_EN is defined)
// Optional feature macro: TNN_RUN_CNT_EN
// ============================================================================
module tnn_run_ctrl #(
  parameter  int FEAT_CNT   = 128,
  parameter  int HIDDEN_CNT = 40,
  parameter  int FEAT_BITS  = 4,
  parameter  int CLASS_CNT  = 6,
  localparam int CLS_W      = $clog2(CLASS_CNT),
  localparam int DATA_W     = FEAT_BITS * FEAT_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] tnn_data,
  output logic              tnn_rst,
  input  logic [CLS_W-1:0]  tnn_prediction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  output logic              busy
`ifdef TNN_RUN_CNT_EN
  ,
  output logic [15:0]       run_cnt
`endif
);

  localparam int RUN_CYC = FEAT_CNT + HIDDEN_CNT;
  localparam int CNT_W   = $clog2(RUN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RUN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             run_last;

  // Next-state and decoded outputs. in_ready is masked by rst so no vector
  // can be taken while the controller is being reset.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    run_last  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = ~rst;
        busy     = 1'b0;
        accept   = in_valid & ~rst;
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        run_last = (cnt == '0);
        if (run_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus the registered datapath. tnn_rst is computed from the
  // next state so it is low exactly in the RUN cycles, without a decode glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tnn_rst   <= 1'b1;
      tnn_data  <= '0;
      out_class <= '0;
      cnt       <= '0;
    end else begin
      state   <= state_nxt;
      tnn_rst <= (state_nxt != S_RUN);
      if (accept) tnn_data <= in_data;
      if (state == S_LOAD) begin
        cnt <= CNT_LOAD;
      end else if ((state == S_RUN) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Prediction is taken at the end of the last released cycle.
      if (run_last) out_class <= tnn_prediction;
    end
  end

`ifdef TNN_RUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (out_valid && out_ready && (run_cnt != 16'hFFFF)) begin
      run_cnt <= run_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tnn_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tnn_run_ctrl
// Description : Directed self-checking bench for tnn_run_ctrl with a small
//               classifier (FEAT_CNT=4, HIDDEN_CNT=3, FEAT_BITS=7, 6 classes,
//               7-cycle evaluation window). A behavioural classifier drives a
//               valid class only in the 7th released cycle and an invalid
//               code otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tnn_run_ctrl;

  localparam int FEAT_CNT   = 4;
  localparam int HIDDEN_CNT = 3;
  localparam int FEAT_BITS  = 7;
  localparam int CLASS_CNT  = 6;
  localparam int CLS_W      = 3;
  localparam int DATA_W     = FEAT_BITS * FEAT_CNT;
  localparam int RUN_CYC    = FEAT_CNT + HIDDEN_CNT;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] tnn_data;
  logic              tnn_rst;
  logic [CLS_W-1:0]  tnn_prediction;
  logic              out_valid;
  logic              out_ready;
  logic [CLS_W-1:0]  out_class;
  logic              busy;
`ifdef TNN_RUN_CNT_EN
  logic [15:0]       run_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  tnn_run_ctrl #(
    .FEAT_CNT  (FEAT_CNT),
    .HIDDEN_CNT(HIDDEN_CNT),
    .FEAT_BITS (FEAT_BITS),
    .CLASS_CNT (CLASS_CNT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .tnn_data      (tnn_data),
    .tnn_rst       (tnn_rst),
    .tnn_prediction(tnn_prediction),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_class     (out_class),
    .busy          (busy)
`ifdef TNN_RUN_CNT_EN
    ,
    .run_cnt       (run_cnt)
`endif
  );

  // Classifier model: the class depends on the presented vector and is only
  // valid in the RUN_CYC-th cycle after rst is released; otherwise code 6.
  function automatic logic [CLS_W-1:0] class_of(input logic [DATA_W-1:0] d);
    class_of = (d[2:0] == 3'd7) ? 3'd5 : d[2:0];
  endfunction

  logic [3:0] model_cnt;
  always @(posedge clk) begin
    if (tnn_rst) model_cnt <= 4'd0;
    else if (model_cnt != 4'hF) model_cnt <= model_cnt + 4'd1;
  end
  assign tnn_prediction = (!tnn_rst && model_cnt == 4'(RUN_CYC - 1)) ? class_of(tnn_data) : 3'd6;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Bounded wait for out_valid; returns the cycle stamp, or -1 on timeout.
  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid) begin
        at = cyc;
        break;
      end
    end
    check("result_timeout", 32'(at >= 0), 32'd1);
  endtask

  int  acc;
  int  v1;
  int  v2;
  logic ok_low;
  logic ok_stable;
  logic saw_valid;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 28'h1234567;
    out_ready = 1'b0;

    // Reset held three cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_tnn_rst", 32'(tnn_rst), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_class", 32'(out_class), 32'd0);
    end
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tnn_data", 32'(tnn_data), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_tnn_rst", 32'(tnn_rst), 32'd1);

    // Single run: accepted at the next edge (E).
    tick();
    check("load_tnn_data", 32'(tnn_data), 32'h1234567);
    check("load_tnn_rst", 32'(tnn_rst), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    check("load_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_data  = 28'h0FFFFFF;
    ok_low   = 1'b1;
    for (int i = 0; i < RUN_CYC; i++) begin
      tick();
      if (tnn_rst !== 1'b0 || out_valid !== 1'b0) ok_low = 1'b0;
    end
    check("run_window_tnn_rst_low", 32'(ok_low), 32'd1);
    tick();
    check("done_tnn_rst", 32'(tnn_rst), 32'd1);
    check("done_out_valid", 32'(out_valid), 32'd1);
    check("done_out_class", 32'(out_class), 32'd5);
    check("run_data_hold", 32'(tnn_data), 32'h1234567);

    // Backpressure for 20 cycles with a new vector offered.
    in_valid  = 1'b1;
    in_data   = 28'hABCDEF2;
    ok_stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_class !== 3'd5 || in_ready !== 1'b0 ||
          tnn_data !== 28'h1234567) ok_stable = 1'b0;
    end
    check("backpressure_stable", 32'(ok_stable), 32'd1);
    out_ready = 1'b1;
    tick();
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();
    acc = cyc;
    check("second_accept_busy", 32'(busy), 32'd1);
    check("second_tnn_data", 32'(tnn_data), 32'hABCDEF2);
    in_valid = 1'b0;
    wait_valid(v1);
    check("second_latency", 32'(v1 - acc), 32'(RUN_CYC + 1));
    check("second_out_class", 32'(out_class), 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("second_idle", 32'(busy), 32'd0);

    // Abort mid-RUN when the down-counter holds 3.
    in_valid = 1'b1;
    in_data  = 28'h0000004;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_in_run", 32'(tnn_rst), 32'd0);
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tnn_rst", 32'(tnn_rst), 32'd1);
    check("abort_out_class", 32'(out_class), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    check("abort_no_valid", 32'(saw_valid), 32'd0);

    // Back-to-back runs with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 28'h0000013;
    tick();
    acc = cyc;
    in_data = 28'h0000021;
    check("b2b_first_data", 32'(tnn_data), 32'h0000013);
    wait_valid(v1);
    check("b2b_first_latency", 32'(v1 - acc), 32'(RUN_CYC + 1));
    check("b2b_first_class", 32'(out_class), 32'd3);
    tick();
    check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    check("b2b_idle_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("b2b_second_data", 32'(tnn_data), 32'h0000021);
    in_valid = 1'b0;
    wait_valid(v2);
    check("b2b_period", 32'(v2 - v1), 32'(RUN_CYC + 3));
    check("b2b_second_class", 32'(out_class), 32'd1);
    tick();
    check("b2b_final_idle", 32'(busy), 32'd0);
`ifdef TNN_RUN_CNT_EN
    check("run_cnt", 32'(run_cnt), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
